// File: rtl/sensor_conditioner.sv
`default_nettype none
//==============================================================================
// Module   : sensor_conditioner
// Purpose  : 2-FF sync and tick-based debounce of six sensor lines; optional
//            per-channel chatter monitor enabled by the CHATTER_EN macro.
// Revision : 1.0 - initial release
//==============================================================================
module sensor_conditioner #(
    parameter int TICK_DIV    = 50000,
    parameter int DEB_TICKS   = 20,
    parameter int WIN_TICKS   = 1000,
    parameter int CHATTER_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] raw_i,
    output logic [5:0] clean_o,
    output logic [5:0] changed_o,
    output logic       tick_o,
    output logic       valid_o,
    output logic [5:0] chatter_o
);

    localparam int c_pw = $clog2(TICK_DIV);
    localparam int c_cw = $clog2(DEB_TICKS + 1);
    localparam logic [c_pw-1:0] c_presc_last = c_pw'(TICK_DIV - 1);
    localparam logic [c_cw-1:0] c_deb_last   = c_cw'(DEB_TICKS - 1);
    localparam logic [c_cw-1:0] c_deb_ticks  = c_cw'(DEB_TICKS);

    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    if (TICK_DIV < 2 || DEB_TICKS < 2 || WIN_TICKS < 2 || CHATTER_MAX < 1) begin : g_bad_params
        $error("sensor_conditioner: parameter out of range");
    end

    logic [5:0]      r_sync1;
    logic [5:0]      r_sync2;
    logic [c_pw-1:0] r_presc;
    logic [c_cw-1:0] r_vcnt;
    logic            r_valid;
    logic            w_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_presc == c_presc_last);

    // valid_o rises once enough ticks have elapsed for every channel to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_vcnt  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_pw'(1);
            if (w_tick && !r_valid) begin
                if (r_vcnt == c_deb_ticks) begin
                    r_valid <= 1'b1;
                end else begin
                    r_vcnt <= r_vcnt + c_cw'(1);
                end
            end
        end
    end

`ifdef CHATTER_EN
    logic [5:0] w_reject;
`endif

    for (genvar n = 0; n < 6; n++) begin : g_chan
        state_t          r_state;
        logic [c_cw-1:0] r_cnt;
        logic            r_clean;
        logic            r_chg;

        // A return to the committed level always wins, even on the commit tick.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
                r_clean <= 1'b0;
                r_chg   <= 1'b0;
            end else begin
                r_chg <= 1'b0;
                case (r_state)
                    ST_STABLE: begin
                        if (r_sync2[n] != r_clean) begin
                            r_state <= ST_PENDING;
                            r_cnt   <= '0;
                        end
                    end
                    ST_PENDING: begin
                        if (r_sync2[n] == r_clean) begin
                            r_state <= ST_STABLE;
                            r_cnt   <= '0;
                        end else if (w_tick) begin
                            if (r_cnt == c_deb_last) begin
                                r_clean <= r_sync2[n];
                                r_chg   <= r_valid;
                                r_state <= ST_STABLE;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + c_cw'(1);
                            end
                        end
                    end
                    default: r_state <= ST_STABLE;
                endcase
            end
        end

        assign clean_o[n]   = r_clean;
        assign changed_o[n] = r_chg;
`ifdef CHATTER_EN
        assign w_reject[n]  = (r_state == ST_PENDING) && (r_sync2[n] == r_clean);
`endif
    end

    assign tick_o  = w_tick;
    assign valid_o = r_valid;

`ifdef CHATTER_EN
    localparam int c_ww = $clog2(WIN_TICKS);
    localparam int c_rw = $clog2(CHATTER_MAX + 1);
    localparam logic [c_ww-1:0] c_win_last = c_ww'(WIN_TICKS - 1);
    localparam logic [c_rw-1:0] c_chat_max = c_rw'(CHATTER_MAX);

    logic [c_ww-1:0] r_win;
    logic [c_rw-1:0] r_rej [6];
    logic [5:0]      r_chat;
    logic            w_win_clr;

    assign w_win_clr = w_tick && (r_win == c_win_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win  <= '0;
            r_chat <= '0;
            for (int i = 0; i < 6; i++) begin
                r_rej[i] <= '0;
            end
        end else begin
            if (w_tick) begin
                r_win <= w_win_clr ? '0 : r_win + c_ww'(1);
            end
            for (int i = 0; i < 6; i++) begin
                if (w_win_clr) begin
                    r_rej[i] <= '0;
                end else if (w_reject[i] && (r_rej[i] != c_chat_max)) begin
                    r_rej[i] <= r_rej[i] + c_rw'(1);
                end
                if (r_rej[i] == c_chat_max) begin
                    r_chat[i] <= 1'b1;
                end
            end
        end
    end

    assign chatter_o = r_chat;
`else
    assign chatter_o = 6'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
//==============================================================================
// Module   : tb_sensor_conditioner
// Purpose  : Scoreboard bench for sensor_conditioner (TICK_DIV=4, DEB_TICKS=3).
// Revision : 1.0 - initial release
//==============================================================================
module tb_sensor_conditioner;

    localparam int TICK_DIV    = 4;
    localparam int DEB_TICKS   = 3;
    localparam int WIN_TICKS   = 16;
    localparam int CHATTER_MAX = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] raw = 6'b0;
    logic [5:0] clean;
    logic [5:0] changed;
    logic       tick;
    logic       valid;
    logic [5:0] chatter;

    int tests_run = 0;
    int failed    = 0;
    int cyc       = 0;

    // Each entry: {expected changed_o, expected clean_o} for one commit event.
    logic [11:0] exp_q[$];
    logic [5:0]  model_clean = 6'b0;

`ifdef CHATTER_EN
    localparam logic [5:0] EXP_CHAT = 6'h08;
`else
    localparam logic [5:0] EXP_CHAT = 6'h00;
`endif

    sensor_conditioner #(
        .TICK_DIV    (TICK_DIV),
        .DEB_TICKS   (DEB_TICKS),
        .WIN_TICKS   (WIN_TICKS),
        .CHATTER_MAX (CHATTER_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raw_i     (raw),
        .clean_o   (clean),
        .changed_o (changed),
        .tick_o    (tick),
        .valid_o   (valid),
        .chatter_o (chatter)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && changed !== 6'b0) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_changed: changed_o=%h clean_o=%h, required no event", changed, clean);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({changed, clean} !== e) begin
                    failed++;
                    $display("FAIL changed_event: changed_o=%h clean_o=%h, required changed_o=%h clean_o=%h",
                             changed, clean, e[11:6], e[5:0]);
                end
            end
        end
    end

    task automatic set_raw(input logic [5:0] v);
        if (v !== model_clean) exp_q.push_back({v ^ model_clean, v});
        raw = v;
        model_clean = v;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int ticks = 0;
        int prev = 0;
        bit done = 0;
        @(negedge clk);
        rst = 1'b1;
        raw = 6'b0;
        #1;
        tests_run++;
        if ({clean, changed, tick, valid, chatter} !== 20'b0) begin
            failed++;
            $display("FAIL reset_outputs: clean=%h changed=%h tick=%b valid=%b chatter=%h, required all 0",
                     clean, changed, tick, valid, chatter);
        end
        exp_q.delete();
        model_clean = 6'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (tick) begin
                ticks++;
                if (ticks > 1) begin
                    tests_run++;
                    if (cyc - prev != TICK_DIV) begin
                        failed++;
                        $display("FAIL tick_period: got %0d cycles, required %0d", cyc - prev, TICK_DIV);
                    end
                end
                prev = cyc;
                if (ticks == DEB_TICKS + 1) begin
                    tests_run++;
                    if (valid !== 1'b0) begin
                        failed++;
                        $display("FAIL valid_early: valid_o=%b on tick %0d, required 0", valid, ticks);
                    end
                    @(negedge clk);
                    tests_run++;
                    if (valid !== 1'b1 || clean !== 6'b0) begin
                        failed++;
                        $display("FAIL valid_rise: valid_o=%b clean_o=%h, required valid_o=1 clean_o=00", valid, clean);
                    end
                    done = 1;
                end
            end
        end
        tests_run++;
        if (!done) begin
            failed++;
            $display("FAIL valid_timeout: saw %0d ticks, required %0d", ticks, DEB_TICKS + 1);
        end
    endtask

    task automatic test_single_commit();
        int start;
        int lat = -1;
        @(negedge clk);
        set_raw(6'h20);
        start = cyc;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (clean[5]) begin
                lat = cyc - start - 1;
                break;
            end
        end
        tests_run++;
        if (lat < 2 + (DEB_TICKS - 1) * TICK_DIV + 1 || lat > 2 + DEB_TICKS * TICK_DIV) begin
            failed++;
            $display("FAIL commit_latency: got %0d cycles, required %0d..%0d", lat,
                     2 + (DEB_TICKS - 1) * TICK_DIV + 1, 2 + DEB_TICKS * TICK_DIV);
        end
        wait_cyc(4);
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL single_events: %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_glitch();
        int bad = 0;
        @(negedge clk);
        raw = model_clean | 6'h01;
        wait_cyc(7);
        raw = model_clean;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (clean !== model_clean) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            failed++;
            $display("FAIL glitch_rejected: clean_o=%h differed on %0d cycles, required %h throughout",
                     clean, bad, model_clean);
        end
    endtask

    task automatic test_simultaneous();
        logic [5:0] first = 6'b0;
        set_raw(6'h00);
        wait_cyc(20);
        set_raw(6'h3F);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (clean !== 6'h00) begin
                first = clean;
                break;
            end
        end
        tests_run++;
        if (first !== 6'h3F) begin
            failed++;
            $display("FAIL simultaneous_commit: first clean_o=%h, required 3f", first);
        end
        wait_cyc(4);
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL simultaneous_events: %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        set_raw(6'h00);
        wait_cyc(20);
        set_raw(6'h10);
        wait_cyc(5);
        set_raw(6'h12);
        wait_cyc(25);
        tests_run++;
        if (exp_q.size() != 0 || clean !== 6'h12) begin
            failed++;
            $display("FAIL back_to_back: clean_o=%h pending=%0d, required clean_o=12 pending=0",
                     clean, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_pending();
        int early = 0;
        bit seen = 0;
        @(negedge clk);
        raw = 6'h16;
        wait_cyc(6);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({clean, changed, valid, chatter} !== 19'b0) begin
            failed++;
            $display("FAIL mid_reset_outputs: clean=%h changed=%h valid=%b chatter=%h, required all 0",
                     clean, changed, valid, chatter);
        end
        exp_q.delete();
        model_clean = 6'h16;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2 + (DEB_TICKS - 1) * TICK_DIV; i++) begin
            @(negedge clk);
            if (clean !== 6'h00) early++;
        end
        tests_run++;
        if (early != 0) begin
            failed++;
            $display("FAIL requalify_early: clean_o nonzero on %0d early cycles, required 0", early);
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        tests_run++;
        if (!seen || clean !== 6'h16) begin
            failed++;
            $display("FAIL requalify_settled: valid_o=%b clean_o=%h, required valid_o=1 clean_o=16", valid, clean);
        end
    endtask

    task automatic test_chatter();
        int bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            raw = model_clean | ((((i / 3) % 2) == 1) ? 6'h08 : 6'h00);
            if (clean !== model_clean) bad++;
        end
        raw = model_clean;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (clean !== model_clean) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            failed++;
            $display("FAIL chatter_clean_stable: clean_o differed on %0d cycles, required %h", bad, model_clean);
        end
        tests_run++;
        if (chatter !== EXP_CHAT) begin
            failed++;
            $display("FAIL chatter_flag: chatter_o=%h, required %h", chatter, EXP_CHAT);
        end
        wait_cyc(80);
        tests_run++;
        if (chatter !== EXP_CHAT) begin
            failed++;
            $display("FAIL chatter_sticky: chatter_o=%h, required %h", chatter, EXP_CHAT);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (chatter !== 6'h00 || clean !== 6'h00) begin
            failed++;
            $display("FAIL chatter_reset: chatter_o=%h clean_o=%h, required 00 00", chatter, clean);
        end
        exp_q.delete();
        model_clean = 6'h00;
        raw = 6'h00;
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(2);
    endtask

    initial begin
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        test_reset();
        test_single_commit();
        test_glitch();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_pending();
        test_chatter();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
